// File: rtl/float_struct.sv
// Shared float payload type for the FPU pipeline slice.
// float_point_num is the single-precision bit layout; FLOAT_ZERO is the reset value.
package float_struct;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } float_point_num;

    localparam float_point_num FLOAT_ZERO = '{sign: 1'b0, exp: '0, mant: '0};

endpackage

// File: rtl/float_pipe_stage.sv
// One elastic register slot: a valid bit plus LANES payload words.
// Reset beats flush, and flush beats a load.
module float_pipe_stage
    import float_struct::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           flush,
    input  logic           load_valid,
    input  float_point_num load_data [LANES],
    input  logic           next_rdy,
    output logic           rdy,
    output logic           valid,
    output float_point_num data [LANES]
);

    // An empty slot always accepts, which is what collapses bubbles.
    assign rdy = next_rdy | ~valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            for (int l = 0; l < int'(LANES); l++) begin
                data[l] <= FLOAT_ZERO;
            end
        end else if (flush) begin
            valid <= 1'b0;
        end else if (en && rdy) begin
            valid <= load_valid;
            data  <= load_data;
        end
    end

endmodule

// File: rtl/float_pipe_elastic.sv
// Elastic STAGES-deep, LANES-wide float pipeline with valid/ready backpressure and flush.
// Define FLOAT_PIPE_OCC_EN to add the registered occupancy output.
module float_pipe_elastic
    import float_struct::*;
#(
    parameter int unsigned STAGES = 6,
    parameter int unsigned LANES  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  float_point_num              in_data  [LANES],
    output logic                        out_valid,
    input  logic                        out_ready,
    output float_point_num              out_data [LANES],
    output logic [STAGES-1:0]           tap_valid,
    output float_point_num              tap_data [STAGES][LANES]
`ifdef FLOAT_PIPE_OCC_EN
    ,
    output logic [$clog2(STAGES+1)-1:0] occupancy
`endif
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] rdy;
    float_point_num    data_q [STAGES][LANES];

    // Each stage pulls from its upstream neighbour; ready ripples back from the tail.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic           src_valid;
        float_point_num src_data [LANES];
        logic           next_rdy;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = valid_q[i-1];
            assign src_data  = data_q[i-1];
        end

        if (i == STAGES - 1) begin : g_tail
            assign next_rdy = out_ready;
        end else begin : g_link
            assign next_rdy = rdy[i+1];
        end

        float_pipe_stage #(
            .LANES(LANES)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .flush     (flush),
            .load_valid(src_valid),
            .load_data (src_data),
            .next_rdy  (next_rdy),
            .rdy       (rdy[i]),
            .valid     (valid_q[i]),
            .data      (data_q[i])
        );
    end

    assign in_ready  = rst & en & ~flush & rdy[0];
    assign out_valid = rst & en & valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign tap_valid = valid_q;
    assign tap_data  = data_q;

`ifdef FLOAT_PIPE_OCC_EN
    localparam int unsigned OCC_W = $clog2(STAGES + 1);

    logic [OCC_W-1:0] occ_q;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Tracks popcount(valid_q) without an adder tree.
    always_ff @(posedge clk) begin
        if (!rst) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ_q <= occ_q + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_q <= occ_q - OCC_W'(1);
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: doc/float_pipe_elastic.md
Name: float_pipe_elastic

Overview:
- Parametrised elastic pipeline for float_point_num payloads. Successor to the fixed shift-register delay line.
- Adds LANES parallel channels per beat, a per-stage valid bit, valid/ready backpressure with bubble collapsing, and a synchronous flush.
- Sits between FPU datapath stages to align operands with multi-cycle units and absorb downstream stalls.

Parameters:
- STAGES, 6, number of register stages (>=1)
- LANES, 1, float_point_num values carried per beat (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- en  in  1  global advance enable; 0 freezes all stages
- flush  in  1  synchronous invalidate of all stages
- in_valid  in  1  upstream beat valid
- in_ready  out  1  pipeline accepts beat this cycle
- in_data  in  float_point_num[0:LANES-1]  upstream beat
- out_valid  out  1  last stage holds a beat
- out_ready  in  1  downstream accepts
- out_data  out  float_point_num[0:LANES-1]  last-stage beat
- tap_valid  out  STAGES  per-stage valid bits
- tap_data  out  float_point_num[0:STAGES-1][0:LANES-1]  per-stage contents

Behaviour:
- Reset (rst==0 at posedge): all valid_q=0; all data_q={sign:0,exp:0,mant:0}. in_ready=0 and out_valid=0 while rst is low.
- State per stage i: valid_q[i], data_q[i][0:LANES-1].
- Ready chain (combinational):
  - rdy[STAGES-1] = out_ready | ~valid_q[STAGES-1]
  - rdy[i] = rdy[i+1] | ~valid_q[i]
- Handshakes:
  - in_ready = en & ~flush & rdy[0]
  - out_valid = en & valid_q[STAGES-1]
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- Stage update when en=1, flush=0:
  - Stage 0 loads in_data with valid=in_valid when rdy[0].
  - Stage i>0 loads stage i-1 (data and valid) when rdy[i].
  - Otherwise the stage holds.
  - A loading stage whose source is invalid becomes invalid; its data is don't-care but is still written.
- Bubble collapsing: an empty stage accepts from upstream even when downstream is stalled.
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready is held 1. Throughput is 1 beat/cycle.
- Backpressure with out_ready=0: at most STAGES beats held; in_ready falls when all stages are valid. No beat is lost or duplicated.
- en=0: no state change, in_ready=0, out_valid=0. Data and tap outputs stay visible.
- flush=1 (with en=1 or en=0): all valid_q cleared next edge and data untouched. in_ready=0 that cycle, so no input is captured. Flush overrides a simultaneous load or output transfer; the downstream must ignore out_valid in a flush cycle.
- Reset has priority over flush and en. A reset mid-operation drops all beats.
- Lanes are independent bit-wise copies; no arithmetic is performed on payloads.
- Beat ordering is strict FIFO.

Optional Feature:
- Macro FLOAT_PIPE_OCC_EN.
- Defined: adds output occupancy [$clog2(STAGES+1)-1:0], a registered count of valid stages.
  - +1 on input transfer without output transfer; -1 on the converse; unchanged otherwise.
  - 0 on reset and after flush.
  - Must always equal popcount(tap_valid).
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package float_struct holds float_point_num (sign 1, exp 8, mant 23) and a constant FLOAT_ZERO used for reset values.
- Natural sub-module: float_pipe_stage, one register slot with valid/data, load/flush inputs and rdy output.
  - Top instantiates STAGES of them via generate and builds the ready chain.

Test Plan:
- STAGES=6, LANES=2, en=1, out_ready=1. Push beats {1.0,-2.0},{3.5,0.0},{inf,NaN} on consecutive cycles -> each appears on out_data exactly 6 cycles later, in order, with lanes unswapped.
- out_ready=0 and push continuously -> in_ready drops after 6 accepted beats. Raise out_ready -> 6 beats drain in order, then new beats flow at 1/cycle.
- Push beat A, idle 3 cycles, push B, then hold out_ready=0 -> A at stage 5 and B collapses to stage 4. tap_valid=6'b110000 (bit i = stage i).
- With 4 beats in flight, pulse flush together with in_valid=1 -> next cycle tap_valid=0, the concurrent beat is not captured, and out_valid stays low for 6 cycles.
- Hold en=0 for 5 cycles mid-stream -> tap_data/tap_valid frozen, in_ready=0, out_valid=0. Resume -> no loss or duplication.
- Assert rst=0 with a full pipe -> next edge all tap_valid=0 and tap_data all zero. With FLOAT_PIPE_OCC_EN, occupancy goes 6->0 and tracks popcount(tap_valid) in all scenarios above.
